// File: rtl/adder_pkg.sv
//------------------------------------------------------------------------------
// Module   : adder_pkg
// Purpose  : Shared constants and helpers for the pipelined chunked adder.
//            - ADDER_CHUNK_DEFAULT : default number of bits added per stage
//            - stage_count()       : pipeline depth for a given width/chunk
//            - width_ok()          : legality test used at elaboration time
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package adder_pkg;

  localparam int ADDER_CHUNK_DEFAULT = 4;

  function automatic int stage_count(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Width must be a whole, non-zero number of chunks.
  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage : adder_pkg

`default_nettype wire

// File: rtl/adder_pipe_stage.sv
//------------------------------------------------------------------------------
// Module   : adder_pipe_stage
// Purpose  : One CHUNK-bit carry-in/carry-out adder slice with its pipeline
//            registers. All registers advance only when en_i is high.
// Ports    : clk, rst_n         clock, asynchronous active-low reset
//            en_i              pipeline advance enable
//            valid_i           valid bit travelling with the operands
//            a_i, b_i          CHUNK-bit operand slices
//            carry_i           carry into bit 0 of this slice
//            valid_o           registered valid
//            sum_o             registered CHUNK-bit partial sum
//            carry_o           registered carry out of the slice MSB
//            ovf_o             registered signed overflow of the slice MSB
//                              (meaningful only on the most significant slice)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adder_pipe_stage
  import adder_pkg::*;
#(
  parameter int CHUNK = ADDER_CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             carry_i,
  output logic             valid_o,
  output logic [CHUNK-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [CHUNK:0]   full_d;
  logic             msb_cin_d;
  logic             valid_q;
  logic [CHUNK-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  assign full_d = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};

  // Carry into the slice MSB recovered from the MSB sum bit; works for CHUNK=1.
  assign msb_cin_d = full_d[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      sum_q   <= full_d[CHUNK-1:0];
      carry_q <= full_d[CHUNK];
      ovf_q   <= msb_cin_d ^ full_d[CHUNK];
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;

endmodule : adder_pipe_stage

`default_nettype wire

// File: rtl/adder_pipe.sv
//------------------------------------------------------------------------------
// Module   : adder_pipe
// Purpose  : Parametrised pipelined ripple adder. Operands are cut into
//            CHUNK-bit slices, one register stage per slice; the carry
//            ripples from stage to stage so timing is independent of WIDTH.
//            Latency is STAGES = WIDTH/CHUNK cycles, throughput one per cycle.
// Ports    : clk, rst_n           clock, asynchronous active-low reset
//            inValid/inReady      input handshake
//            inA, inB, inCarry    operands and carry-in
//            inSub                subtract select (ADDER_PIPE_SUB_EN only)
//            outValid/outReady    output handshake
//            outSum               (inA + inB + inCarry) mod 2^WIDTH
//            outCarry             carry out of bit WIDTH-1 (1 = no borrow
//                                 when subtracting)
//            outOverflow          two's-complement overflow
// Options  : `define ADDER_PIPE_SUB_EN adds inSub; when high the block
//            computes inA - inB (uses ~inB with carry-in forced to 1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = ADDER_CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inCarry,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             inSub,
`endif
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outSum,
  output logic             outCarry,
  output logic             outOverflow
);

  localparam int STAGES = stage_count(WIDTH, CHUNK);

  if (!width_ok(WIDTH, CHUNK)) begin : g_width_check
    $error("adder_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Global stall: everything moves together or nothing moves.
  assign adv     = !outValid || outReady;
  assign inReady = adv;

`ifdef ADDER_PIPE_SUB_EN
  // Subtraction is folded in at the input: the inverted B travels down the
  // skew registers, so later stages need no knowledge of the operation.
  assign b_eff   = inSub ? ~inB : inB;
  assign cin_eff = inSub | inCarry;
`else
  assign b_eff   = inB;
  assign cin_eff = inCarry;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             cin;
    logic             valid_in;
    logic             valid_w;
    logic [CHUNK-1:0] sum_w;
    logic             carry_w;
    logic             ovf_w;

    if (k == 0) begin : g_src_in
      assign a_chunk  = inA[CHUNK-1:0];
      assign b_chunk  = b_eff[CHUNK-1:0];
      assign cin      = cin_eff;
      assign valid_in = inValid;
    end else begin : g_src_prev
      assign a_chunk  = g_stage[k-1].g_skew.a_hi_q[CHUNK-1:0];
      assign b_chunk  = g_stage[k-1].g_skew.b_hi_q[CHUNK-1:0];
      assign cin      = g_stage[k-1].carry_w;
      assign valid_in = g_stage[k-1].valid_w;
    end

    adder_pipe_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (adv),
      .valid_i (valid_in),
      .a_i     (a_chunk),
      .b_i     (b_chunk),
      .carry_i (cin),
      .valid_o (valid_w),
      .sum_o   (sum_w),
      .carry_o (carry_w),
      .ovf_o   (ovf_w)
    );

    // Skew: operand chunks above this stage, waiting for their turn. The
    // low chunk of each register feeds the next stage's adder.
    if (k < STAGES - 1) begin : g_skew
      localparam int HI_W = WIDTH - (k + 1) * CHUNK;
      logic [HI_W-1:0] a_hi_d;
      logic [HI_W-1:0] b_hi_d;
      logic [HI_W-1:0] a_hi_q;
      logic [HI_W-1:0] b_hi_q;

      if (k == 0) begin : g_from_in
        assign a_hi_d = inA[WIDTH-1:CHUNK];
        assign b_hi_d = b_eff[WIDTH-1:CHUNK];
      end else begin : g_from_prev
        assign a_hi_d = g_stage[k-1].g_skew.a_hi_q[HI_W+CHUNK-1:CHUNK];
        assign b_hi_d = g_stage[k-1].g_skew.b_hi_q[HI_W+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (adv) begin
          a_hi_q <= a_hi_d;
          b_hi_q <= b_hi_d;
        end
      end

      // Slice overflow is only meaningful at the MSB slice.
      logic ovf_unused;
      assign ovf_unused = ovf_w;
    end

    // Deskew: completed lower sum chunks, kept aligned with this stage's
    // registered chunk.
    if (k > 0) begin : g_deskew
      logic [k*CHUNK-1:0] sum_lo_d;
      logic [k*CHUNK-1:0] sum_lo_q;

      if (k == 1) begin : g_from_first
        assign sum_lo_d = g_stage[0].sum_w;
      end else begin : g_from_prev
        assign sum_lo_d = {g_stage[k-1].sum_w, g_stage[k-1].g_deskew.sum_lo_q};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_lo_q <= '0;
        end else if (adv) begin
          sum_lo_q <= sum_lo_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      assign outValid    = valid_w;
      assign outCarry    = carry_w;
      assign outOverflow = ovf_w;
      if (k == 0) begin : g_sum_single
        assign outSum = sum_w;
      end else begin : g_sum_join
        assign outSum = {sum_w, g_stage[k].g_deskew.sum_lo_q};
      end
    end
  end

endmodule : adder_pipe

`default_nettype wire

// File: tb/tb_adder_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_adder_pipe
// Purpose  : Self-checking bench for adder_pipe (WIDTH=16, CHUNK=4) plus a
//            single-stage instance (WIDTH=8, CHUNK=8). Expected results come
//            from a behavioural model and are queued at input transfer, then
//            popped and compared at output transfer.
// Options  : honours ADDER_PIPE_SUB_EN (drives inSub, adds subtract cases).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_adder_pipe;

  localparam int W      = 16;
  localparam int STAGES = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    int           issue;
    bit           chk_lat;
  } sb_entry_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inValid, inReady, inCarry, outValid, outReady, outCarry, outOverflow;
  logic [W-1:0] inA, inB, outSum;
  logic         inSub;

  // Single-stage instance signals
  logic         s_inValid, s_inReady, s_inCarry, s_outValid, s_outCarry, s_outOverflow;
  logic [7:0]   s_inA, s_inB, s_outSum;
  logic         s_inSub;

  int        cyc = 0;
  int        n_checks = 0;
  int        n_pass = 0;
  sb_entry_t sb[$];
  sb_entry_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_pipe #(.WIDTH(W), .CHUNK(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inValid     (inValid),
    .inReady     (inReady),
    .inA         (inA),
    .inB         (inB),
    .inCarry     (inCarry),
`ifdef ADDER_PIPE_SUB_EN
    .inSub       (inSub),
`endif
    .outValid    (outValid),
    .outReady    (outReady),
    .outSum      (outSum),
    .outCarry    (outCarry),
    .outOverflow (outOverflow)
  );

  adder_pipe #(.WIDTH(8), .CHUNK(8)) dut_single (
    .clk         (clk),
    .rst_n       (rst_n),
    .inValid     (s_inValid),
    .inReady     (s_inReady),
    .inA         (s_inA),
    .inB         (s_inB),
    .inCarry     (s_inCarry),
`ifdef ADDER_PIPE_SUB_EN
    .inSub       (s_inSub),
`endif
    .outValid    (s_outValid),
    .outReady    (1'b1),
    .outSum      (s_outSum),
    .outCarry    (s_outCarry),
    .outOverflow (s_outOverflow)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic sb_entry_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input logic sub);
    sb_entry_t    r;
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full;
    bb      = sub ? ~b : b;
    c       = sub ? 1'b1 : cin;
    full    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    r.sum   = full[W-1:0];
    r.carry = full[W];
    r.ovf   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    r.issue = 0;
    r.chk_lat = 1'b0;
    return r;
  endfunction

  // Drive one operand set; call at posedge+1, returns at posedge+1 after transfer.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input bit lat);
    sb_entry_t e;
    bit        done = 1'b0;
    inValid = 1'b1; inA = a; inB = b; inCarry = cin; inSub = sub;
    for (int w = 0; w < 64 && !done; w++) begin
      @(negedge clk);
      if (inReady) begin
        e = model(a, b, cin, sub);
        e.issue   = cyc + 1;
        e.chk_lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check_val("send_timeout", {31'b0, inReady}, 32'd1);
    inValid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && sb.size() != 0; w++) begin
      @(posedge clk); #1;
    end
    check_val("drain_empty", sb.size(), 0);
  endtask

  // Output monitor: compares every output transfer against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && outValid && outReady) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", {31'b0, outValid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("sum",   {16'b0, outSum},      {16'b0, mon_e.sum});
        check_val("carry", {31'b0, outCarry},    {31'b0, mon_e.carry});
        check_val("ovf",   {31'b0, outOverflow}, {31'b0, mon_e.ovf});
        if (mon_e.chk_lat) check_val("latency", cyc - mon_e.issue + 1, STAGES);
      end
    end
  end

  initial begin
    rst_n = 1'b0; inValid = 1'b0; inA = '0; inB = '0; inCarry = 1'b0; inSub = 1'b0;
    outReady = 1'b1;
    s_inValid = 1'b0; s_inA = '0; s_inB = '0; s_inCarry = 1'b0; s_inSub = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_outValid", {31'b0, outValid},    32'd0);
    check_val("rst_outSum",   {16'b0, outSum},      32'd0);
    check_val("rst_outCarry", {31'b0, outCarry},    32'd0);
    check_val("rst_outOvf",   {31'b0, outOverflow}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_inReady", {31'b0, inReady}, 32'd1);
    @(posedge clk); #1;

    // Single op and carry-chain boundaries
    send(16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b1);
    drain();
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
    drain();

    // Back-to-back random stream, one result per cycle
    for (int i = 0; i < 20; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
    drain();

    // Backpressure: fill with outReady low, hold, then release
    outReady = 1'b0;
    for (int i = 0; i < STAGES; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_inReady",  {31'b0, inReady},  32'd0);
      check_val("stall_outValid", {31'b0, outValid}, 32'd1);
      check_val("stall_sum",      {16'b0, outSum},   {16'b0, sb[0].sum});
      check_val("stall_carry",    {31'b0, outCarry}, {31'b0, sb[0].carry});
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    for (int i = 0; i < 6; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
    drain();

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++)
      send(W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("midrst_outValid", {31'b0, outValid}, 32'd0);
    check_val("midrst_outSum",   {16'b0, outSum},   32'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    send(16'hA5A5, 16'h1111, 1'b1, 1'b0, 1'b1);
    drain();

`ifdef ADDER_PIPE_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    drain();
`endif

    // Single-stage instance: latency 1
    s_inValid = 1'b1; s_inCarry = 1'b1; s_inA = 8'hF0; s_inB = 8'h20;
`ifdef ADDER_PIPE_SUB_EN
    s_inSub = 1'b1; s_inA = 8'h05; s_inB = 8'h07;
`endif
    @(negedge clk);
    check_val("single_inReady", {31'b0, s_inReady}, 32'd1);
    @(posedge clk); #1 s_inValid = 1'b0;
    @(negedge clk);
    check_val("single_outValid", {31'b0, s_outValid}, 32'd1);
`ifdef ADDER_PIPE_SUB_EN
    check_val("single_sum",   {24'b0, s_outSum},   32'hFE);
    check_val("single_carry", {31'b0, s_outCarry}, 32'd0);
`else
    check_val("single_sum",   {24'b0, s_outSum},   32'h11);
    check_val("single_carry", {31'b0, s_outCarry}, 32'd1);
`endif
    check_val("single_ovf", {31'b0, s_outOverflow}, 32'd0);
    @(negedge clk);
    check_val("single_bubble", {31'b0, s_outValid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_adder_pipe

`default_nettype wire

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined ripple adder. It is the next-generation replacement for the fixed-width chained-nibble adders.
- Operands are split into CHUNK-bit segments, with one register stage per segment. The carry ripples between stages, so clock frequency does not depend on WIDTH.
- Operands enter and results leave through valid/ready handshakes, so the block can sit directly between streaming producers and consumers in datapath/ALU pipelines.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be a multiple of CHUNK and ≥ CHUNK.
- CHUNK, 4: bits added per pipeline stage.
- STAGES, WIDTH/CHUNK: derived, not overridable. Pipeline depth and latency in cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inValid  in  1  input operands valid.
- inReady  out  1  block can accept an operand set this cycle.
- inA  in  WIDTH  operand A.
- inB  in  WIDTH  operand B.
- inCarry  in  1  carry-in to bit 0.
- outValid  out  1  result valid.
- outReady  in  1  downstream accepts result.
- outSum  out  WIDTH  (inA + inB + inCarry) mod 2^WIDTH.
- outCarry  out  1  carry out of bit WIDTH-1.
- outOverflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: asserting rst_n=0 asynchronously clears every stage valid bit and all data/carry registers. Reset values: outValid=0, outSum=0, outCarry=0, outOverflow=0. inReady=1 once rst_n is deasserted. In-flight operands are discarded; no partial result is ever presented after reset.
- Advance enable: adv = !outValid || outReady. The whole pipeline shifts only when adv=1 (global stall). inReady = adv (combinational).
- Transfer rules: an input transfer happens when inValid && inReady; an output transfer happens when outValid && outReady.
- Stage k (k = 0..STAGES-1), on adv:
  - adds chunk k of A and B plus the carry registered by stage k-1 (inCarry for stage 0);
  - registers the CHUNK-bit partial sum, the carry, and the stage valid bit;
  - skews the upper, not-yet-added operand chunks forward;
  - deskews the completed lower sum chunks forward, so all WIDTH sum bits emerge aligned.
- Latency: exactly STAGES cycles from input transfer to outValid, with no stalls (4 cycles for the defaults).
- Throughput: one result per cycle while outReady=1.
- Bubbles: when inValid=0 with adv=1, stage 0 loads valid=0; the bubble propagates and is not compressed.
- Stall: while outValid=1 && outReady=0, every register holds its value and outputs are stable.
- Full pipeline plus simultaneous input and output transfer: the pipeline shifts, and both transfers complete in the same cycle.
- Wrap-around: sums exceeding 2^WIDTH-1 wrap modulo 2^WIDTH, with outCarry=1.
- outOverflow is registered with the final stage and is valid only when outValid=1.
- Degenerate case WIDTH==CHUNK: a single stage, latency 1.

Optional Feature:
- Macro: ADDER_PIPE_SUB_EN.
- When defined:
  - an extra input port inSub (1 bit) travels with each operand set;
  - when inSub=1, the block uses ~inB and forces carry-in to 1, ignoring inCarry, so outSum = inA - inB;
  - outCarry=1 means no borrow;
  - outOverflow follows the signed-subtraction rule.
- When undefined: the port is absent and behaviour is plain addition.

Decomposition:
- Package adder_pkg:
  - ADDER_CHUNK_DEFAULT constant;
  - function stage_count(width, chunk);
  - elaboration check that WIDTH % CHUNK == 0.
- Sub-module adder_pipe_stage:
  - one CHUNK-bit carry-in/carry-out adder plus its enable-gated registers;
  - instantiated STAGES times in a generate loop.
- Skew/deskew registers live in the top level.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
1. Single op: A=0x1234, B=0x0F0F, cin=0, outReady=1 → outValid on cycle 4, outSum=0x2143, outCarry=0, outOverflow=0.
2. Carry chain: A=0xFFFF, B=0x0000, cin=1 → outSum=0x0000, outCarry=1, outOverflow=0. A=0x7FFF, B=0x0001 → outSum=0x8000, outOverflow=1.
3. Back-to-back stream of 20 random pairs, outReady=1 → results 4..23 cycles after issue, one per cycle, in order, matching the reference model.
4. Backpressure: fill the pipeline, drop outReady for 5 cycles → inReady=0 and outSum/outValid held stable throughout. Restore outReady → no loss or duplication.
5. Reset mid-stream: rst_n low for 1 cycle with 3 ops in flight → outValid=0 immediately. After release, no stale result appears and a new op returns on cycle 4.
6. ADDER_PIPE_SUB_EN defined: A=0x0005, B=0x0007, inSub=1 → outSum=0xFFFE, outCarry=0. Repeat with WIDTH=8, CHUNK=8 → latency 1.
